// File: rtl/fixed_point_math.sv
// Shared fixed-point definitions for the biquad cascade: Q8.24 format,
// accumulator width, saturation limits and coefficient/state enumerations.
package fixed_point_math;

  localparam int FRAC_BITS_DEF = 24;
  localparam int NUM_COEF      = 5;
  localparam int ACC_W         = 67;

  localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;

  typedef enum logic [2:0] {
    COEF_B0 = 3'd0,
    COEF_B1 = 3'd1,
    COEF_B2 = 3'd2,
    COEF_A1 = 3'd3,
    COEF_A2 = 3'd4
  } coef_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Clamp a wide signed value into the signed 32-bit range.
  function automatic logic signed [31:0] sat32(input logic signed [ACC_W-1:0] v);
    logic signed [31:0] r;
    if (v[ACC_W-1:31] == {(ACC_W-31){v[ACC_W-1]}}) begin
      r = v[31:0];
    end else if (v[ACC_W-1]) begin
      r = SAT_MIN;
    end else begin
      r = SAT_MAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_mac.sv
// Single shared 32x32 signed multiplier feeding a 67-bit accumulator, with the
// Q-format rescale (floor shift) and 32-bit saturation of the result.
module fixed_mac
  import fixed_point_math::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  input  logic               sub,
  input  logic signed [31:0] coef,
  input  logic signed [31:0] data,
  output logic signed [31:0] y_new
);

  logic signed [63:0]      prod_s;
  logic signed [ACC_W-1:0] prod_ext_s;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] acc_sh_s;

  assign prod_s     = coef * data;
  assign prod_ext_s = {{(ACC_W-64){prod_s[63]}}, prod_s};
  assign acc_sh_s   = acc_r >>> FRAC_BITS;
  assign y_new      = sat32(acc_sh_s);

  // Accumulator: cleared at each section start, one product per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= sub ? (acc_r - prod_ext_s) : (acc_r + prod_ext_s);
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/biquad_sched.sv
// Time-multiplexed cascade of biquad sections sharing one multiplier, with
// shadow/active coefficient banks swapped only while idle.
module biquad_sched
  import fixed_point_math::*;
#(
  parameter int NUM_SECTIONS = 4,
  parameter int FRAC_BITS    = FRAC_BITS_DEF,
  localparam int SEC_W       = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] x_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] y_out,
  input  logic               coef_we,
  input  logic [SEC_W-1:0]   coef_sec,
  input  logic [2:0]         coef_idx,
  input  logic signed [31:0] coef_data,
  input  logic               coef_commit,
  output logic               busy
);

  localparam logic signed [31:0] COEF_ONE = 32'sd1 <<< FRAC_BITS;

  state_e              state_r, state_nxt_s;
  coef_idx_e           step_r;
  logic [SEC_W-1:0]    sec_r;
  logic                pending_r;
  logic signed [31:0]  sec_in_r;
  logic                out_valid_r;
  logic signed [31:0]  y_out_r;

  logic signed [31:0]  x1_r [NUM_SECTIONS];
  logic signed [31:0]  x2_r [NUM_SECTIONS];
  logic signed [31:0]  y1_r [NUM_SECTIONS];
  logic signed [31:0]  y2_r [NUM_SECTIONS];
  logic signed [31:0]  shadow_r [NUM_SECTIONS][NUM_COEF];
  logic signed [31:0]  active_r [NUM_SECTIONS][NUM_COEF];

  logic                in_ready_s, accept_s, copy_s, last_sec_s;
  logic                mac_clear_s, mac_en_s, mac_sub_s;
  logic signed [31:0]  coef_s, data_s, y_new_s;

  assign in_ready_s  = (state_r == ST_IDLE) && !pending_r;
  assign accept_s    = in_valid && in_ready_s;
  assign copy_s      = (state_r == ST_IDLE) && pending_r;
  assign last_sec_s  = (sec_r == SEC_W'(NUM_SECTIONS - 1));
  assign mac_clear_s = accept_s || (state_r == ST_WB);
  assign mac_en_s    = (state_r == ST_MAC);
  assign mac_sub_s   = (step_r == COEF_A1) || (step_r == COEF_A2);

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign y_out     = y_out_r;
  assign busy      = (state_r != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = accept_s ? ST_MAC : ST_IDLE;
      ST_MAC:  state_nxt_s = (step_r == COEF_A2) ? ST_WB : ST_MAC;
      ST_WB:   state_nxt_s = last_sec_s ? ST_OUT : ST_MAC;
      ST_OUT:  state_nxt_s = out_ready ? ST_IDLE : ST_OUT;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand selection for the current MAC step of the current section.
  always_comb begin
    coef_s = '0;
    data_s = '0;
    case (step_r)
      COEF_B0: begin coef_s = active_r[sec_r][0]; data_s = sec_in_r;       end
      COEF_B1: begin coef_s = active_r[sec_r][1]; data_s = x1_r[sec_r];    end
      COEF_B2: begin coef_s = active_r[sec_r][2]; data_s = x2_r[sec_r];    end
      COEF_A1: begin coef_s = active_r[sec_r][3]; data_s = y1_r[sec_r];    end
      COEF_A2: begin coef_s = active_r[sec_r][4]; data_s = y2_r[sec_r];    end
      default: begin coef_s = '0;                 data_s = '0;             end
    endcase
  end

  fixed_mac #(.FRAC_BITS(FRAC_BITS)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (mac_clear_s),
    .en    (mac_en_s),
    .sub   (mac_sub_s),
    .coef  (coef_s),
    .data  (data_s),
    .y_new (y_new_s)
  );

  // Sequencing counters, section histories and the registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_r       <= '0;
      step_r      <= COEF_B0;
      sec_in_r    <= '0;
      out_valid_r <= 1'b0;
      y_out_r     <= '0;
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        x1_r[s] <= '0;
        x2_r[s] <= '0;
        y1_r[s] <= '0;
        y2_r[s] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            sec_r    <= '0;
            step_r   <= COEF_B0;
            sec_in_r <= x_in;
          end
        end
        ST_MAC: begin
          step_r <= (step_r == COEF_A2) ? COEF_B0 : coef_idx_e'(step_r + 3'd1);
        end
        ST_WB: begin
          x2_r[sec_r] <= x1_r[sec_r];
          x1_r[sec_r] <= sec_in_r;
          y2_r[sec_r] <= y1_r[sec_r];
          y1_r[sec_r] <= y_new_s;
          sec_in_r    <= y_new_s;
          if (last_sec_s) begin
            out_valid_r <= 1'b1;
            y_out_r     <= y_new_s;
          end else begin
            sec_r <= sec_r + SEC_W'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient banks: the shadow is writable anytime, the active copy only
  // changes in IDLE so an in-flight sample sees one coherent set.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        for (int c = 0; c < NUM_COEF; c++) begin
          shadow_r[s][c] <= (c == 0) ? COEF_ONE : 32'sd0;
          active_r[s][c] <= (c == 0) ? COEF_ONE : 32'sd0;
        end
      end
    end else begin
      if (copy_s) begin
        active_r <= shadow_r;
      end
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        for (int c = 0; c < NUM_COEF; c++) begin
          if (coef_we && (coef_sec == SEC_W'(s)) && (coef_idx == 3'(c))) begin
            shadow_r[s][c] <= coef_data;
          end
        end
      end
    end
  end

  // A commit arriving on the copy edge re-arms pending so its data is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= 1'b0;
    end else if (copy_s) begin
      pending_r <= coef_commit;
    end else if (coef_commit) begin
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

endmodule

// File: doc/biquad_sched.md
BIQUAD_SCHED -- requirements
Module: biquad_sched

Interface
REQ-001 SHALL have parameter NUM_SECTIONS, default 4: number of cascaded biquad sections sharing one multiplier.
REQ-002 SHALL have parameter FRAC_BITS, default 24: fractional bits of the signed 32-bit fixed-point format (Q8.24).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  x_in holds a sample.
REQ-006 in_ready  out  1  block accepts a sample this cycle.
REQ-007 x_in  in  32  signed input sample.
REQ-008 out_valid  out  1  y_out holds a result.
REQ-009 out_ready  in  1  consumer accepts the result.
REQ-010 y_out  out  32  signed cascade output.
REQ-011 coef_we  in  1  write coef_data into the shadow coefficient bank.
REQ-012 coef_sec  in  clog2(NUM_SECTIONS)  target section for coef_we.
REQ-013 coef_idx  in  3  0=B0, 1=B1, 2=B2, 3=A1, 4=A2; values 5-7 ignored.
REQ-014 coef_data  in  32  signed coefficient.
REQ-015 coef_commit  in  1  request a shadow-to-active bank copy.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement y[n] = B0*x[n] + B1*x[n-1] + B2*x[n-2] - A1*y[n-1] - A2*y[n-2] per section; section k input = section k-1 output; section 0 input = x_in.
REQ-018 SHALL use exactly one 32x32 signed multiplier, time-multiplexed, one product per cycle.
REQ-019 States: IDLE, MAC, WB, OUT.
REQ-020 in_ready = (state==IDLE) && !pending; a sample is accepted on an edge with in_valid && in_ready; the next state is MAC, with section 0 and step 0 selected.
REQ-021 MAC: 5 cycles per section (steps B0, B1, B2, A1, A2); each product is added or subtracted into a 67-bit signed accumulator at full 64-bit precision; the accumulator is cleared at section start.
REQ-022 WB: 1 cycle; y_new = accumulator arithmetic-shifted right by FRAC_BITS (truncation toward minus infinity), saturated to [0x8000_0000, 0x7FFF_FFFF].
REQ-023 WB edge updates: x2<=x1, x1<=section input, y2<=y1, y1<=y_new, next section input<=y_new; then MAC for the next section, or OUT after the last section.
REQ-024 Latency: out_valid SHALL rise in the cycle after edge E0+6*NUM_SECTIONS, where E0 is the accepting edge (24 cycles for the default).
REQ-025 OUT: out_valid=1; y_out holds the final y_new stable until the edge with out_ready=1, which returns the state to IDLE; no new sample is accepted while in OUT.
REQ-026 coef_we writes the shadow bank in any state, including on an edge where a commit happens.
REQ-027 coef_commit sets pending; a repeated commit while pending has no additional effect.
REQ-028 When state==IDLE and pending=1, the next edge copies shadow to active and clears pending.
REQ-029 The active bank SHALL never change while in MAC, WB or OUT, so an in-flight sample always uses one coherent coefficient set.
REQ-030 coef_we and coef_commit on the same edge: the written value is included in the copy.

Reset
REQ-031 reset SHALL force: state IDLE, out_valid=0, y_out=0, busy=0, pending=0, all x/y histories and accumulator 0.
REQ-032 reset SHALL load both banks with B0=1<<FRAC_BITS and B1=B2=A1=A2=0 (passthrough).
REQ-033 reset asserted mid-operation SHALL abort the in-flight sample without producing any out_valid pulse.

Structure
REQ-034 The fixed_point_math package SHALL hold FRAC_BITS default, saturation limits, and the coef_idx enumeration.
REQ-035 The multiply/accumulate/shift/saturate path SHALL be sub-module fixed_mac; sequencing, banks and histories stay in biquad_sched.

Verification
REQ-036 After reset, x_in=0x0100_0000 -> y_out=0x0100_0000, out_valid rising in the cycle after E0+24.
REQ-037 Write sec0 B0=0x0080_0000, commit, x_in=0x0100_0000 -> y_out=0x0080_0000; in_ready low for exactly the one swap cycle.
REQ-038 sec0 B0=0x0100_0000, A1=0xFF80_0000; impulse 0x0100_0000 then zeros -> y_out 0x0100_0000, 0x0080_0000, 0x0040_0000, 0x0020_0000.
REQ-039 sec0 and sec1 B0=0x7F00_0000: x_in=0x0100_0000 -> 0x7FFF_FFFF; x_in=0xFF00_0000 -> 0x8000_0000.
REQ-040 Hold out_ready=0 for 10 cycles in OUT -> y_out stable and in_ready=0; a commit during MAC leaves that sample on the old coefficients, and the next sample uses the new ones.
REQ-041 Assert reset 10 cycles after acceptance -> no out_valid; the next sample x_in=0x0100_0000 -> 0x0100_0000 (passthrough, histories zero).
